polaris_tluh_initiator: RTL
===========================

POLARIS_TLUH_INITIATOR -- requirements
Module: polaris_tluh_initiator

Interface
REQ-001 SHALL have parameters: SOURCE_ID, default 0, a_source driven on every A beat; TL_RS, default 1, source field width; TIMEOUT, default 1023, D-wait cycles before local timeout (1..65535).
REQ-002 SHALL have port tlm_clk_i  input  1  sole clock, rising edge.
REQ-003 SHALL have port tlm_rst_i  input  1  reset, asynchronous, active-high.
REQ-004 SHALL have port req_valid_i  input  1  host request valid.
REQ-005 SHALL have port req_ready_o  output  1  host request accepted when high with req_valid_i.
REQ-006 SHALL have ports req_op_i  input  3  TL A opcode; req_param_i  input  3; req_size_i  input  2; req_addr_i  input  32; req_mask_i  input  4; req_wdata_i  input  32.
REQ-007 SHALL have port rsp_valid_o  output  1  response valid; rsp_ready_i  input  1  host consumes response.
REQ-008 SHALL have ports rsp_rdata_o  output  32; rsp_denied_o  output  1; rsp_corrupt_o  output  1; rsp_timeout_o  output  1.
REQ-009 SHALL have port tluh_o  output  tluh::tluh_m2s  A-channel fields to slave; tluh_i  input  tluh::tluh_s2m  D-channel fields from slave.
REQ-010 SHALL have port a_ready_i  input  1  slave accepts A; d_ready_o  output  1  initiator accepts D.
REQ-011 SHALL have port stale_o  output  1  sticky flag, unexpected D beat dropped.

Function
REQ-012 SHALL implement FSM IDLE, REQ, WAIT, RSP; at most one transaction outstanding.
REQ-013 req_ready_o SHALL equal (state==IDLE), combinational.
REQ-014 IDLE + req_valid_i with op in {PutFullData, PutPartialData, ArithmeticData, LogicalData, Get}: register all A fields into tluh_o, a_source=SOURCE_ID, a_corrupt=0, a_valid=1 next cycle, go REQ.
REQ-015 IDLE + req_valid_i with illegal op (5,6,7): no A beat; go RSP next cycle with rsp_denied_o=1, rsp_rdata_o=0, others 0.
REQ-016 REQ: a_valid and A fields SHALL hold stable until a_valid&a_ready_i; on that edge a_valid=0, clear timeout counter, go WAIT.
REQ-017 d_ready_o SHALL be 1 in IDLE, REQ and WAIT, 0 in RSP.
REQ-018 WAIT: d_valid with d_source==SOURCE_ID and d_opcode in {AccessAck, AccessAckData} -> capture rsp_denied_o=d_denied, rsp_corrupt_o=d_corrupt, rsp_rdata_o=d_data if AccessAckData else 0, rsp_timeout_o=0; go RSP.
REQ-019 D beat with d_valid&d_ready_o outside WAIT, or in WAIT with wrong source/opcode, SHALL be dropped and set stale_o=1; stale_o clears only on reset.
REQ-020 WAIT: 16-bit counter increments each cycle without a matching D; at count==TIMEOUT go RSP with rsp_timeout_o=1, rsp_denied_o=1, rsp_rdata_o=0; matching D on the same cycle wins over timeout.
REQ-021 RSP: rsp_valid_o=1, data stable until rsp_valid_o&rsp_ready_i; then rsp_valid_o=0, go IDLE; a new request may be accepted the cycle after.
REQ-022 Minimum latency, request accept to rsp_valid_o, with a_ready_i and D returned immediately: 3 cycles (A beat cycle 1, D beat cycle 2, rsp cycle 3).
REQ-023 Late D after timeout SHALL be dropped per REQ-019, never delivered to the host.

Reset
REQ-024 tlm_rst_i SHALL force asynchronously: state=IDLE, tluh_o.a_valid=0, all other tluh_o fields 0, rsp_valid_o=0, rsp_* data 0, counter 0, stale_o=0.
REQ-025 Reset mid-transaction SHALL abandon it; no A retry; a D beat arriving after reset release is dropped and sets stale_o.

Verification
REQ-026 Get addr 0x0200BFF8, a_ready_i=1, slave returns AccessAckData d_data=0x12345678 next cycle -> rsp_rdata_o=0x12345678, denied=0, rsp_valid_o 3 cycles after accept.
REQ-027 PutFullData data 0x1, a_ready_i low 5 cycles -> A fields stable all 5 cycles, single A handshake, AccessAck -> rsp_rdata_o=0.
REQ-028 TIMEOUT=8, slave never responds -> rsp_timeout_o=1, rsp_denied_o=1 exactly 8 cycles into WAIT; later D dropped, stale_o=1.
REQ-029 req_op_i=7 -> no a_valid, rsp_denied_o=1 next cycle; rsp_ready_i held low 4 cycles -> response stable, d_ready_o=0.
REQ-030 LogicalData param=1 in flight, assert tlm_rst_i in WAIT -> all outputs zero immediately; post-reset D with source SOURCE_ID -> stale_o=1, rsp_valid_o stays 0.

Source files
------------

// File: rtl/polaris_tluh_initiator.sv
// polaris_tluh_initiator: single-outstanding TileLink-UH style initiator.
// A host request becomes one A beat to the slave. The matching D beat
// becomes one host response. If no D beat arrives within TIMEOUT cycles
// of A acceptance, a local timeout response is returned instead.
// Ports:
//   tlm_clk_i / tlm_rst_i        clock, async active-high reset
//   req_*                        host request (valid/ready, A fields)
//   rsp_*                        host response (valid/ready, data, status)
//   tluh_o / a_ready_i           A channel to slave
//   tluh_i / d_ready_o           D channel from slave
//   stale_o                      sticky: an unexpected D beat was dropped

package tluh;
  localparam int unsigned SRC_W = 8;

  typedef struct packed {
    logic             a_valid;
    logic [2:0]       a_opcode;
    logic [2:0]       a_param;
    logic [1:0]       a_size;
    logic [SRC_W-1:0] a_source;
    logic [31:0]      a_address;
    logic [3:0]       a_mask;
    logic [31:0]      a_data;
    logic             a_corrupt;
  } tluh_m2s;

  typedef struct packed {
    logic             d_valid;
    logic [2:0]       d_opcode;
    logic [1:0]       d_param;
    logic [1:0]       d_size;
    logic [SRC_W-1:0] d_source;
    logic             d_denied;
    logic [31:0]      d_data;
    logic             d_corrupt;
  } tluh_s2m;

  localparam logic [2:0] OP_ACCESS_ACK      = 3'd0;
  localparam logic [2:0] OP_ACCESS_ACK_DATA = 3'd1;
  localparam logic [2:0] OP_GET             = 3'd4;
endpackage

module polaris_tluh_initiator #(
  parameter int unsigned SOURCE_ID = 0,
  parameter int unsigned TL_RS     = 1,
  parameter int unsigned TIMEOUT   = 1023
) (
  input  logic           tlm_clk_i,
  input  logic           tlm_rst_i,
  input  logic           req_valid_i,
  output logic           req_ready_o,
  input  logic [2:0]     req_op_i,
  input  logic [2:0]     req_param_i,
  input  logic [1:0]     req_size_i,
  input  logic [31:0]    req_addr_i,
  input  logic [3:0]     req_mask_i,
  input  logic [31:0]    req_wdata_i,
  output logic           rsp_valid_o,
  input  logic           rsp_ready_i,
  output logic [31:0]    rsp_rdata_o,
  output logic           rsp_denied_o,
  output logic           rsp_corrupt_o,
  output logic           rsp_timeout_o,
  output tluh::tluh_m2s  tluh_o,
  input  tluh::tluh_s2m  tluh_i,
  input  logic           a_ready_i,
  output logic           d_ready_o,
  output logic           stale_o
);

  // Source ID truncated to the configured source-field width.
  localparam logic [tluh::SRC_W-1:0] SRC     = tluh::SRC_W'(SOURCE_ID % (2 ** TL_RS));
  localparam logic [15:0]            TO_LAST = 16'(TIMEOUT - 1);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_RSP} state_t;

  state_t      state;
  state_t      state_nxt;
  logic [15:0] wait_cnt;
  logic        op_legal;
  logic        d_fire;
  logic        d_match;
  logic        timeout_hit;
  logic        unused_d;

  assign unused_d = ^{tluh_i.d_param, tluh_i.d_size};

  assign op_legal = (req_op_i <= tluh::OP_GET);
  assign d_fire   = tluh_i.d_valid & d_ready_o;
  assign d_match  = d_fire && (state == S_WAIT) && (tluh_i.d_source == SRC) &&
                    ((tluh_i.d_opcode == tluh::OP_ACCESS_ACK) ||
                     (tluh_i.d_opcode == tluh::OP_ACCESS_ACK_DATA));
  // A matching D beat in the final wait cycle takes priority over timeout.
  assign timeout_hit = (state == S_WAIT) && !d_match && (wait_cnt == TO_LAST);

  always_ff @(posedge tlm_clk_i or posedge tlm_rst_i) begin
    if (tlm_rst_i) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt   = state;
    req_ready_o = 1'b0;
    d_ready_o   = 1'b1;
    case (state)
      S_IDLE: begin
        req_ready_o = 1'b1;
        if (req_valid_i) begin
          state_nxt = op_legal ? S_REQ : S_RSP;
        end
      end
      S_REQ: begin
        if (a_ready_i) begin
          state_nxt = S_WAIT;
        end
      end
      S_WAIT: begin
        if (d_match || timeout_hit) begin
          state_nxt = S_RSP;
        end
      end
      S_RSP: begin
        d_ready_o = 1'b0;
        if (rsp_ready_i) begin
          state_nxt = S_IDLE;
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge tlm_clk_i or posedge tlm_rst_i) begin
    if (tlm_rst_i) begin
      tluh_o        <= '0;
      wait_cnt      <= '0;
      rsp_valid_o   <= 1'b0;
      rsp_rdata_o   <= '0;
      rsp_denied_o  <= 1'b0;
      rsp_corrupt_o <= 1'b0;
      rsp_timeout_o <= 1'b0;
      stale_o       <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (req_valid_i && op_legal) begin
            tluh_o.a_valid   <= 1'b1;
            tluh_o.a_opcode  <= req_op_i;
            tluh_o.a_param   <= req_param_i;
            tluh_o.a_size    <= req_size_i;
            tluh_o.a_source  <= SRC;
            tluh_o.a_address <= req_addr_i;
            tluh_o.a_mask    <= req_mask_i;
            tluh_o.a_data    <= req_wdata_i;
            tluh_o.a_corrupt <= 1'b0;
          end else if (req_valid_i) begin
            rsp_valid_o   <= 1'b1;
            rsp_rdata_o   <= '0;
            rsp_denied_o  <= 1'b1;
            rsp_corrupt_o <= 1'b0;
            rsp_timeout_o <= 1'b0;
          end
        end
        S_REQ: begin
          if (a_ready_i) begin
            tluh_o.a_valid <= 1'b0;
            wait_cnt       <= '0;
          end
        end
        S_WAIT: begin
          if (d_match) begin
            rsp_valid_o   <= 1'b1;
            rsp_rdata_o   <= (tluh_i.d_opcode == tluh::OP_ACCESS_ACK_DATA) ? tluh_i.d_data : '0;
            rsp_denied_o  <= tluh_i.d_denied;
            rsp_corrupt_o <= tluh_i.d_corrupt;
            rsp_timeout_o <= 1'b0;
          end else if (timeout_hit) begin
            rsp_valid_o   <= 1'b1;
            rsp_rdata_o   <= '0;
            rsp_denied_o  <= 1'b1;
            rsp_corrupt_o <= 1'b0;
            rsp_timeout_o <= 1'b1;
          end else begin
            wait_cnt <= wait_cnt + 16'd1;
          end
        end
        S_RSP: begin
          if (rsp_ready_i) begin
            rsp_valid_o <= 1'b0;
          end
        end
        default: ;
      endcase
      if (d_fire && !d_match) begin
        stale_o <= 1'b1;
      end
    end
  end

endmodule
